// File: rtl/dot_i8_seq.sv
// dot_i8_seq: streams long signed int8 vectors through one k-lane dot_i8
// datapath and emits one accumulated scalar result per vector.

// dot_i8: combinational k-lane signed dot product of one beat.
module dot_i8 #(
    parameter int bit_width = 8,
    parameter int k = 4,
    localparam int dp_width = 2 * bit_width + $clog2(k)
) (
    input  logic [k-1:0][bit_width-1:0] i_vec_a,
    input  logic [k-1:0][bit_width-1:0] i_vec_b,
    output logic signed [dp_width-1:0]  o_dp
);

    logic signed [2*bit_width-1:0] prod;

    // Sum of sign-extended lane products; the $clog2(k) guard bits absorb
    // the carry growth of adding k full-scale products.
    always_comb begin
        o_dp = '0;
        prod = '0;
        for (int i = 0; i < k; i++) begin
            prod = $signed(i_vec_a[i]) * $signed(i_vec_b[i]);
            o_dp = o_dp + dp_width'(prod);
        end
    end

endmodule

module dot_i8_seq #(
    parameter int bit_width = 8,
    parameter int k = 4,
    parameter int max_beats = 16,
    localparam int dp_width = 2 * bit_width + $clog2(k),
    localparam int acc_width = dp_width + $clog2(max_beats),
    localparam int cnt_width = $clog2(max_beats + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [k-1:0][bit_width-1:0] i_vec_a,
    input  logic [k-1:0][bit_width-1:0] i_vec_b,
    input  logic                         i_last,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic signed [acc_width-1:0] o_dp,
    output logic [cnt_width-1:0]         o_beats,
    output logic                         o_len_err
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic signed [acc_width-1:0] acc_q, acc_d;
    logic [cnt_width-1:0]        cnt_q, cnt_d;
    logic signed [acc_width-1:0] dp_q, dp_d;
    logic [cnt_width-1:0]        beats_q, beats_d;
    logic                        len_err_q, len_err_d;

    logic signed [dp_width-1:0]  dp_part;
    logic signed [acc_width-1:0] dp_ext;
    logic signed [acc_width-1:0] sum;
    logic [cnt_width-1:0]        cnt_inc;
    logic                        accept;
    logic                        at_max;
    logic                        end_vec;

    dot_i8 #(
        .bit_width(bit_width),
        .k        (k)
    ) u_dot (
        .i_vec_a(i_vec_a),
        .i_vec_b(i_vec_b),
        .o_dp   (dp_part)
    );

    // Handshake flags depend on state only, so neither side sees a
    // combinational path through this block.
    always_comb begin
        o_ready = (state_q == ST_ACC);
        o_valid = (state_q == ST_OUT);
    end

    // Running sum: a zero count marks the first beat, which loads the
    // partial directly instead of needing a separate clear cycle.
    always_comb begin
        dp_ext  = acc_width'(dp_part);
        cnt_inc = cnt_q + 1'b1;
        at_max  = (cnt_inc == cnt_width'(max_beats));
        accept  = i_valid & o_ready;
        end_vec = i_last | at_max;
        if (cnt_q == '0) begin
            sum = dp_ext;
        end else begin
            sum = acc_q + dp_ext;
        end
    end

    // Next state: accumulate in ACC, capture the result on the final beat,
    // and hold the result in OUT until the consumer takes it.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dp_d      = dp_q;
        beats_d   = beats_q;
        len_err_d = len_err_q;
        unique case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (end_vec) begin
                        state_d   = ST_OUT;
                        dp_d      = sum;
                        beats_d   = cnt_inc;
                        len_err_d = at_max & ~i_last;
                        acc_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_OUT: begin
                if (i_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State and result registers; reset drops any partial or pending result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            dp_q      <= '0;
            beats_q   <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            dp_q      <= dp_d;
            beats_q   <= beats_d;
            len_err_q <= len_err_d;
        end
    end

    // Result outputs are driven straight from registers.
    always_comb begin
        o_dp      = dp_q;
        o_beats   = beats_q;
        o_len_err = len_err_q;
    end

endmodule

// File: tb/tb_dot_i8_seq.sv
// tb_dot_i8_seq: directed-vector bench for dot_i8_seq with
// hand-computed expected results.
module tb_dot_i8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready_dut;
    logic [3:0][7:0] vec_a;
    logic [3:0][7:0] vec_b;
    logic        last;
    logic        res_valid;
    logic        res_ready;
    logic signed [21:0] dp;
    logic [4:0]  beats;
    logic        len_err;

    int checks = 0;
    int errors = 0;

    dot_i8_seq dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (in_valid),
        .o_ready  (out_ready_dut),
        .i_vec_a  (vec_a),
        .i_vec_b  (vec_b),
        .i_last   (last),
        .o_valid  (res_valid),
        .i_ready  (res_ready),
        .o_dp     (dp),
        .o_beats  (beats),
        .o_len_err(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int e0, input int e1,
                                       input int e2, input int e3);
        logic [31:0] v;
        v[7:0]   = e0[7:0];
        v[15:8]  = e1[7:0];
        v[23:16] = e2[7:0];
        v[31:24] = e3[7:0];
        return v;
    endfunction

    task automatic beat(input logic [31:0] a, input logic [31:0] b,
                        input logic l);
        in_valid = 1'b1;
        vec_a    = a;
        vec_b    = b;
        last     = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        last     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_res(input string tag, input longint d,
                           input longint nb, input longint e);
        chk({tag, "_valid"}, longint'(res_valid), 1);
        chk({tag, "_dp"}, longint'(dp), d);
        chk({tag, "_beats"}, longint'(beats), nb);
        chk({tag, "_lenerr"}, longint'(len_err), e);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        vec_a     = '0;
        vec_b     = '0;
        last      = 1'b0;
        res_ready = 1'b1;

        // reset state
        #12;
        chk("rst_valid", longint'(res_valid), 0);
        chk("rst_dp", longint'(dp), 0);
        chk("rst_beats", longint'(beats), 0);
        chk("rst_lenerr", longint'(len_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", longint'(out_ready_dut), 1);

        // single beat: 5+12+21+32 = 70
        beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1);
        chk_res("single", 70, 1, 0);
        chk("single_rdy", longint'(out_ready_dut), 0);
        idle(1);
        chk("single_drop", longint'(res_valid), 0);
        chk("single_rdy1", longint'(out_ready_dut), 1);

        // three beats of -128 * -128 per lane: 3 * 4 * 16384
        beat(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b0);
        beat(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b0);
        beat(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b1);
        chk_res("neg3", 196608, 3, 0);
        // next vector offered right away; taken one cycle after handshake
        beat(pk(1, 1, 1, 1), pk(2, 2, 2, 2), 1'b1);
        chk("b2b_valid0", longint'(res_valid), 0);
        chk("b2b_ready", longint'(out_ready_dut), 1);
        @(posedge clk);
        #1;
        chk_res("b2b", 8, 1, 0);
        idle(1);

        // 16 beats without last: forced end at max_beats
        for (int i = 0; i < 16; i++) begin
            beat(pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1'b0);
        end
        chk_res("trunc", 16, 16, 1);
        // 17th beat starts a fresh vector
        beat(pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1'b1);
        @(posedge clk);
        #1;
        chk_res("trunc_next", 1, 1, 0);
        idle(1);

        // result stall with upstream still offering a beat
        res_ready = 1'b0;
        beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0);
        beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1);
        chk_res("stall0", 140, 2, 0);
        in_valid = 1'b1;
        vec_a    = pk(1, 1, 1, 1);
        vec_b    = pk(2, 2, 2, 2);
        last     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_res("stall", 140, 2, 0);
            chk("stall_rdy", longint'(out_ready_dut), 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_rel_valid", longint'(res_valid), 0);
        chk("stall_rel_rdy", longint'(out_ready_dut), 1);
        @(posedge clk);
        #1;
        chk_res("stall_next", 8, 1, 0);
        idle(1);
        chk("stall_done", longint'(res_valid), 0);

        // gapped mixed-sign vector: 4 * (-127 + 128 + 0 - 128)
        for (int i = 0; i < 4; i++) begin
            beat(pk(127, -128, 0, 1), pk(-1, -1, 5, -128), 1'(i == 3));
            if (i != 3) begin
                idle(2);
                chk("gap_valid", longint'(res_valid), 0);
            end
        end
        chk_res("gap", -508, 4, 0);
        idle(1);

        // reset after two beats discards the partial sum
        beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0);
        beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rstmid_valid", longint'(res_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b1);
        chk_res("rstmid", 4, 1, 0);
        idle(1);

        // reset while a result is pending
        res_ready = 1'b0;
        beat(pk(1, 1, 1, 1), pk(2, 2, 2, 2), 1'b1);
        chk_res("rstout0", 8, 1, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rstout_valid", longint'(res_valid), 0);
        chk("rstout_dp", longint'(dp), 0);
        chk("rstout_beats", longint'(beats), 0);
        res_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstout_stale", longint'(res_valid), 0);
        beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b1);
        chk_res("rstout", 4, 1, 0);
        idle(1);
        chk("end_valid", longint'(res_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_i8_seq.md
Name: dot_i8_seq

Overview:
Sequencer that streams arbitrarily long signed int8 vectors through one k-lane dot_i8 datapath, which it instantiates internally. Each accepted beat carries k element pairs. The block accumulates the per-beat partial dot products across a vector and emits one scalar result per vector. It sits between an operand streamer and the MX block-scaling logic, using valid/ready on both sides.

Parameters:
bit_width, 8, element width in bits (signed two's complement).
k, 4, lanes per beat, passed to dot_i8.
max_beats, 16, maximum beats per vector; must be 2 or greater.
dp_width, 2*bit_width+$clog2(k), width of the dot_i8 partial result (derived).
acc_width, dp_width+$clog2(max_beats), accumulator and result width (derived).

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_valid  in  1  beat valid.
o_ready  out  1  beat ready.
i_vec_a  in  bit_width x k (signed array)  operand A lanes.
i_vec_b  in  bit_width x k (signed array)  operand B lanes.
i_last  in  1  marks the final beat of a vector.
o_valid  out  1  result valid.
i_ready  in  1  result consumer ready.
o_dp  out  acc_width (signed)  accumulated dot product.
o_beats  out  $clog2(max_beats+1)  number of beats in this result.
o_len_err  out  1  vector was truncated at max_beats.

Behaviour:
- Reset: i_rst_n low asynchronously clears all state. State=ACC, acc=0, beat count=0, o_valid=0, o_dp=0, o_beats=0, o_len_err=0, o_ready=1 once reset is released. Reset mid-vector or mid-output discards the partial result with no output.
- Accept: an input beat is accepted on a cycle where i_valid and o_ready are both high. Inputs are stable only on that edge.
- dot_i8 is combinational. On accept, acc <= acc + sign_extend(dp_partial) and count <= count + 1. On the first beat of a vector, acc <= sign_extend(dp_partial), with no separate clear cycle.
- FSM state ACC: o_ready=1, o_valid=0. Move to OUT on an accepted beat when i_last=1 or count+1==max_beats.
- On that transition, o_dp is loaded with the final sum including the current beat. o_beats = count+1. o_len_err = 1 when the transition is forced by max_beats with i_last=0. Then acc and count clear.
- FSM state OUT: o_valid=1, o_ready=0. o_dp, o_beats and o_len_err hold stable while i_ready is low. Return to ACC on the cycle o_valid and i_ready are both high. o_valid drops the following cycle.
- Latency: result is valid 1 cycle after the last beat is accepted.
- Throughput: 1 beat per cycle inside a vector, plus exactly 1 bubble per vector (the OUT cycle, assuming i_ready=1).
- Truncation: after a forced end, the next accepted beat starts a new vector even if the upstream considers it a continuation. o_len_err is informational only.
- Arithmetic: all signed. acc_width guarantees no overflow for max_beats beats of the worst-case products ((-2^(bit_width-1))^2 per lane). No saturation logic.
- Single-beat vector (i_last on the first beat): o_dp = dp_partial sign-extended, o_beats=1.
- i_valid low mid-vector: acc and count hold with no timeout.
- o_valid must not depend combinationally on i_ready. o_ready depends only on state.

Test Plan:
- Reset, then a single beat a={1,2,3,4}, b={5,6,7,8}, i_last=1 -> 1 cycle later o_valid=1, o_dp=70, o_beats=1, o_len_err=0; o_ready=0 until the result handshake.
- 3-beat vector, all lanes a=-128 and b=-128, i_last on beat 3 -> o_dp=196608, o_beats=3; back-to-back next vector accepted 1 cycle after the result handshake.
- 16 beats with i_last=0 and max_beats=16, each beat dp=+1 -> o_dp=16, o_beats=16, o_len_err=1. The 17th beat starts a new vector with acc equal to that beat's dp only.
- Result stall: hold i_ready=0 for 5 cycles with i_valid=1 upstream -> o_dp and o_beats stable, o_ready=0, no beat consumed. Release -> exactly one handshake, then ACC.
- Gapped input: beats of a 4-beat vector with i_valid low 2 cycles between each, mixed signs a={127,-128,0,1}, b={-1,-1,5,-128} repeated -> o_dp=4*(-127+128+0-128)=-508.
- Assert i_rst_n low mid-vector (after 2 beats) and during OUT -> outputs clear immediately, no stale result. The next vector {1,1,1,1}·{1,1,1,1} with i_last gives o_dp=4.
